decode_stage: RTL and testbench

//  RV32I instruction decode stage sitting directly upstream of regFile.
//  - Drives the regFile rs1/rs2 read controls from the incoming instruction.
//  - Registers the decoded fields (rd, immediate, format, funct bits) into a valid/ready pipeline slot for execute.
//  - Keeps a 32-entry scoreboard of pending writes, cleared by writeback, and stalls fetch on RAW/WAW hazards.

---
 rtl/decode_stage_if.sv | 49 ++++
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundles the fetch-side handshake, the regFile read controls,
//                the execute-side output slot and the writeback retire port
//                of the RV32I decode stage.
//                  master : environment (fetch / regFile / execute / WB)
//                  slave  : decode_stage
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // fetch -> decode
    logic                  iValid;
    logic                  oReady;
    logic [31:0]           iInstr;
    logic [DATA_WIDTH-1:0] iPc;
    logic                  iFlush;
    // decode -> regFile read ports, {en, addr[4:0]}
    logic [5:0]            oRs1Cntrl;
    logic [5:0]            oRs2Cntrl;
    // decode -> execute slot
    logic                  oValid;
    logic                  iReady;
    logic [DATA_WIDTH-1:0] oPc;
    logic [4:0]            oRdAddr;
    logic                  oRdWe;
    logic [DATA_WIDTH-1:0] oImm;
    logic [2:0]            oFmt;
    logic [2:0]            oFunct3;
    logic                  oFunct7b5;
    // writeback retire
    logic                  iWbEn;
    logic [4:0]            iWbAddr;

    modport master (
        output iValid, iInstr, iPc, iFlush, iReady, iWbEn, iWbAddr,
        input  oReady, oRs1Cntrl, oRs2Cntrl, oValid, oPc, oRdAddr, oRdWe,
               oImm, oFmt, oFunct3, oFunct7b5
    );

    modport slave (
        input  iValid, iInstr, iPc, iFlush, iReady, iWbEn, iWbAddr,
        output oReady, oRs1Cntrl, oRs2Cntrl, oValid, oPc, oRdAddr, oRdWe,
               oImm, oFmt, oFunct3, oFunct7b5
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I decode stage in front of regFile. Drives the rs1/rs2
//                read controls in the accept cycle, registers the decoded
//                fields into a valid/ready slot for execute and keeps a
//                pending-write scoreboard that stalls fetch on RAW/WAW.
//  Ports       : iClk  - clock, rising edge
//                iRst  - synchronous reset, active low
//                bus   - decode_stage_if.slave (fetch, regFile controls,
//                        execute slot, writeback retire)
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  wire logic     iClk,
    input  wire logic     iRst,
    decode_stage_if.slave bus
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]           instr;
    logic [4:0]            rs1, rs2, rd;
    logic [2:0]            fmt;
    logic                  rs1_used, rs2_used, rd_written;
    logic [DATA_WIDTH-1:0] imm;

    assign instr = bus.iInstr;
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign rd    = instr[11:7];

    always_comb begin
        unique case (instr[6:0])
            7'b0110011:                                  fmt = FMT_R;
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011:                      fmt = FMT_I;
            7'b0100011:                                  fmt = FMT_S;
            7'b1100011:                                  fmt = FMT_B;
            7'b0110111, 7'b0010111:                      fmt = FMT_U;
            7'b1101111:                                  fmt = FMT_J;
            default:                                     fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        rs1_used   = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
        rs2_used   = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        rd_written = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                     && (rd != 5'd0);
    end

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I: imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            FMT_S: imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            // instr[31] doubles as the sign-extension source for widths > 32
            FMT_U: imm = {{(DATA_WIDTH-31){instr[31]}}, instr[30:12], 12'b0};
            FMT_J: imm = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot and scoreboard state
    // ------------------------------------------------------------------
    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] pc_q,      pc_d;
    logic [4:0]            rd_addr_q, rd_addr_d;
    logic                  rd_we_q,   rd_we_d;
    logic [DATA_WIDTH-1:0] imm_q,     imm_d;
    logic [2:0]            fmt_q,     fmt_d;
    logic [2:0]            funct3_q,  funct3_d;
    logic                  f7b5_q,    f7b5_d;
    logic [REG_COUNT-1:0]  busy_q,    busy_d;

    // A writer still sitting in the slot has not reached the scoreboard yet,
    // so it is folded in here to catch back-to-back dependencies.
    logic [REG_COUNT-1:0] pending;
    logic                 hazard, ready, accept, consume;

    assign pending = busy_q | ((valid_q && rd_we_q) ? (REG_COUNT'(1) << rd_addr_q)
                                                    : '0);

    assign hazard  = (rs1_used   && pending[rs1])
                  || (rs2_used   && pending[rs2])
                  || (rd_written && pending[rd]);

    assign ready   = iRst && !bus.iFlush && !hazard && (!valid_q || bus.iReady);
    assign accept  = bus.iValid && ready;
    // A flushed slot is killed, so it is never handed to execute.
    assign consume = valid_q && bus.iReady && !bus.iFlush;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rd_addr_d = rd_addr_q;
        rd_we_d   = rd_we_q;
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        funct3_d  = funct3_q;
        f7b5_d    = f7b5_q;
        busy_d    = busy_q;

        if (accept) begin
            valid_d   = 1'b1;
            pc_d      = bus.iPc;
            rd_addr_d = rd;
            rd_we_d   = rd_written;
            imm_d     = imm;
            fmt_d     = fmt;
            funct3_d  = instr[14:12];
            f7b5_d    = instr[30];
        end else if (bus.iFlush || consume) begin
            valid_d   = 1'b0;
        end

        // Clear first so a same-cycle set on the same register wins.
        if (bus.iWbEn) begin
            busy_d[bus.iWbAddr] = 1'b0;
        end
        if (consume && rd_we_q) begin
            busy_d[rd_addr_q] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd_addr_q <= '0;
            rd_we_q   <= 1'b0;
            imm_q     <= '0;
            fmt_q     <= '0;
            funct3_q  <= '0;
            f7b5_q    <= 1'b0;
            busy_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rd_addr_q <= rd_addr_d;
            rd_we_q   <= rd_we_d;
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            funct3_q  <= funct3_d;
            f7b5_q    <= f7b5_d;
            busy_q    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.oReady    = ready;
    assign bus.oRs1Cntrl = (accept && rs1_used) ? {1'b1, rs1} : 6'd0;
    assign bus.oRs2Cntrl = (accept && rs2_used) ? {1'b1, rs2} : 6'd0;
    assign bus.oValid    = valid_q;
    assign bus.oPc       = pc_q;
    assign bus.oRdAddr   = rd_addr_q;
    assign bus.oRdWe     = rd_we_q;
    assign bus.oImm      = imm_q;
    assign bus.oFmt      = fmt_q;
    assign bus.oFunct3   = funct3_q;
    assign bus.oFunct7b5 = f7b5_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed bench for decode_stage: reset state, format and
//                immediate decode, regFile read controls, slot hold/consume,
//                flush, scoreboard stalls and writeback clearing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    decode_stage_if #(.DATA_WIDTH(32)) bus ();

    decode_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        bus.iValid  = 1'b0;
        bus.iInstr  = 32'h0;
        bus.iPc     = 32'h0;
        bus.iFlush  = 1'b0;
        bus.iReady  = 1'b0;
        bus.iWbEn   = 1'b0;
        bus.iWbAddr = 5'd0;

        // ---------------- reset ----------------
        tick(); tick();
        iRst = 1'b1;
        #1;
        check("rst_valid", 32'(bus.oValid),    32'd0);
        check("rst_pc",    bus.oPc,            32'd0);
        check("rst_imm",   bus.oImm,           32'd0);
        check("rst_rd",    32'(bus.oRdAddr),   32'd0);
        check("rst_we",    32'(bus.oRdWe),     32'd0);
        check("rst_fmt",   32'(bus.oFmt),      32'd0);
        check("rst_f3",    32'(bus.oFunct3),   32'd0);
        check("rst_f7",    32'(bus.oFunct7b5), 32'd0);

        // ---------------- addi x1,x0,5 ----------------
        bus.iValid = 1'b1; bus.iInstr = 32'h00500093; bus.iPc = 32'h100;
        #1;
        check("addi_ready", 32'(bus.oReady),    32'd1);
        check("addi_rs1",   32'(bus.oRs1Cntrl), 32'h20);
        check("addi_rs2",   32'(bus.oRs2Cntrl), 32'h00);
        tick();
        bus.iValid = 1'b0;
        #1;
        check("addi_valid", 32'(bus.oValid),    32'd1);
        check("addi_rd",    32'(bus.oRdAddr),   32'd1);
        check("addi_we",    32'(bus.oRdWe),     32'd1);
        check("addi_imm",   bus.oImm,           32'd5);
        check("addi_fmt",   32'(bus.oFmt),      32'd1);
        check("addi_pc",    bus.oPc,            32'h100);
        check("idle_rs1",   32'(bus.oRs1Cntrl), 32'h00);

        // ---------------- add x3,x1,x2 : RAW on x1 ----------------
        bus.iReady = 1'b1; bus.iValid = 1'b1; bus.iInstr = 32'h002081B3; bus.iPc = 32'h104;
        #1;
        check("raw_slot_stall", 32'(bus.oReady), 32'd0);
        tick();
        check("raw_consumed",   32'(bus.oValid), 32'd0);
        check("raw_busy_stall", 32'(bus.oReady), 32'd0);
        tick();
        check("raw_busy_stall2", 32'(bus.oReady), 32'd0);
        bus.iWbEn = 1'b1; bus.iWbAddr = 5'd1;
        #1;
        check("raw_no_bypass", 32'(bus.oReady), 32'd0);
        tick();
        bus.iWbEn = 1'b0;
        #1;
        check("add_ready", 32'(bus.oReady),    32'd1);
        check("add_rs1",   32'(bus.oRs1Cntrl), 32'h21);
        check("add_rs2",   32'(bus.oRs2Cntrl), 32'h22);
        tick();
        bus.iValid = 1'b0;
        #1;
        check("add_valid", 32'(bus.oValid),  32'd1);
        check("add_fmt",   32'(bus.oFmt),    32'd0);
        check("add_rd",    32'(bus.oRdAddr), 32'd3);
        tick();                                 // consume: busy[3] set
        bus.iWbEn = 1'b1; bus.iWbAddr = 5'd3;
        tick();
        bus.iWbEn = 1'b0;

        // ---------------- sw x2,8(x1) ----------------
        bus.iReady = 1'b0; bus.iValid = 1'b1; bus.iInstr = 32'h0020A423;
        #1;
        check("sw_ready", 32'(bus.oReady),    32'd1);
        check("sw_rs1",   32'(bus.oRs1Cntrl), 32'h21);
        check("sw_rs2",   32'(bus.oRs2Cntrl), 32'h22);
        tick();
        bus.iValid = 1'b0;
        #1;
        check("sw_fmt", 32'(bus.oFmt),    32'd2);
        check("sw_imm", bus.oImm,         32'd8);
        check("sw_we",  32'(bus.oRdWe),   32'd0);
        check("sw_f3",  32'(bus.oFunct3), 32'd2);
        bus.iReady = 1'b1;
        tick();
        check("sw_consumed", 32'(bus.oValid), 32'd0);
        bus.iInstr = 32'h000404B3;              // add x9,x8,x0: x8 must not be busy
        #1;
        check("sw_no_busy", 32'(bus.oReady), 32'd1);

        // ---------------- beq x0,x0,-4 then lui x5 ----------------
        bus.iValid = 1'b1; bus.iInstr = 32'hFE000EE3;
        #1;
        check("beq_rs1", 32'(bus.oRs1Cntrl), 32'h20);
        check("beq_rs2", 32'(bus.oRs2Cntrl), 32'h20);
        tick();
        bus.iInstr = 32'h123452B7;
        #1;
        check("beq_imm",   bus.oImm,           32'hFFFFFFFC);
        check("beq_fmt",   32'(bus.oFmt),      32'd3);
        check("lui_ready", 32'(bus.oReady),    32'd1);
        check("lui_rs1",   32'(bus.oRs1Cntrl), 32'h00);
        check("lui_rs2",   32'(bus.oRs2Cntrl), 32'h00);
        tick();
        check("lui_imm", bus.oImm,         32'h12345000);
        check("lui_fmt", 32'(bus.oFmt),    32'd4);
        check("lui_rd",  32'(bus.oRdAddr), 32'd5);

        // ---------------- hold for 3 cycles, then flush ----------------
        bus.iReady = 1'b0; bus.iInstr = 32'h00500093;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", 32'(bus.oReady),  32'd0);
            check("hold_valid", 32'(bus.oValid),  32'd1);
            check("hold_imm",   bus.oImm,         32'h12345000);
            check("hold_rd",    32'(bus.oRdAddr), 32'd5);
            tick();
        end
        bus.iFlush = 1'b1;
        #1;
        check("flush_ready", 32'(bus.oReady), 32'd0);
        tick();
        bus.iFlush = 1'b0; bus.iValid = 1'b0;
        bus.iInstr = 32'h00128313;              // addi x6,x5,1: x5 must not be busy
        #1;
        check("flush_valid",   32'(bus.oValid), 32'd0);
        check("flush_no_busy", 32'(bus.oReady), 32'd1);

        // ---------------- set/clear collision on x7 ----------------
        bus.iValid = 1'b1; bus.iInstr = 32'h00700393;   // addi x7,x0,7
        tick();
        bus.iValid = 1'b0; bus.iReady = 1'b1;
        bus.iWbEn = 1'b1; bus.iWbAddr = 5'd7;
        tick();
        bus.iWbEn = 1'b0; bus.iReady = 1'b0;
        bus.iValid = 1'b1; bus.iInstr = 32'h40038433;   // sub x8,x7,x0
        #1;
        check("x7_set_wins", 32'(bus.oReady), 32'd0);
        tick();
        check("x7_still_busy", 32'(bus.oReady), 32'd0);
        bus.iWbEn = 1'b1; bus.iWbAddr = 5'd7;
        #1;
        check("x7_no_bypass", 32'(bus.oReady), 32'd0);
        tick();
        bus.iWbEn = 1'b0;
        #1;
        check("x7_cleared", 32'(bus.oReady),    32'd1);
        check("sub_rs1",    32'(bus.oRs1Cntrl), 32'h27);
        check("sub_rs2",    32'(bus.oRs2Cntrl), 32'h20);
        tick();
        bus.iValid = 1'b0;
        #1;
        check("sub_valid", 32'(bus.oValid),    32'd1);
        check("sub_rd",    32'(bus.oRdAddr),   32'd8);
        check("sub_f7b5",  32'(bus.oFunct7b5), 32'd1);

        // ---------------- illegal opcode ----------------
        bus.iReady = 1'b1; bus.iValid = 1'b1; bus.iInstr = 32'hFFFFFFFF;
        #1;
        check("ill_ready", 32'(bus.oReady),    32'd1);
        check("ill_rs1",   32'(bus.oRs1Cntrl), 32'h00);
        check("ill_rs2",   32'(bus.oRs2Cntrl), 32'h00);
        tick();
        bus.iValid = 1'b0; bus.iReady = 1'b0;
        #1;
        check("ill_fmt", 32'(bus.oFmt),  32'd7);
        check("ill_imm", bus.oImm,       32'd0);
        check("ill_we",  32'(bus.oRdWe), 32'd0);

        // ---------------- reset mid-operation clears scoreboard ----------------
        bus.iReady = 1'b1; bus.iInstr = 32'h000404B3;   // reads x8, busy from sub
        #1;
        check("x8_busy", 32'(bus.oReady), 32'd0);
        iRst = 1'b0;
        tick();
        iRst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.oValid), 32'd0);
        check("mid_rst_fmt",   32'(bus.oFmt),   32'd0);
        check("mid_rst_sb",    32'(bus.oReady), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
